// File: rtl/shim_pkg.sv
// rtl/shim_pkg.sv - shared sync-header codes, terminate threshold and release FSM states
package shim_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;
  localparam logic [7:0] TERM_MIN  = 8'h87;

  typedef enum logic [1:0] {
    IDLE,
    RELEASE,
    GAP
  } state_e;

endpackage

// File: rtl/shim_term_detect.sv
// rtl/shim_term_detect.sv - flags a 64b/66b control block whose type byte marks a packet terminate
module shim_term_detect
  import shim_pkg::*;
(
  input  logic [1:0]  sync,
  input  logic [63:0] d,
  output logic        is_term
);

  // Only the block-type byte matters; the rest of the payload is carried through.
  logic unused_payload;
  assign unused_payload = ^d[63:8];

  assign is_term = (sync == SYNC_CTRL) && (d[7:0] >= TERM_MIN);

endmodule

// File: rtl/shim_release_ctrl.sv
// rtl/shim_release_ctrl.sv - drains the shim queue one whole packet at a time
// with a programmable idle gap after every released terminate.
module shim_release_ctrl
  import shim_pkg::*;
#(
  parameter int PKT_CNT_W = 8,
  parameter int MIN_GAP   = 2,
  parameter int GAP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           shim_inc,
  input  logic [63:0]          shim_ind,
  input  logic                 shimq_write,
  input  logic [1:0]           shim_outc,
  input  logic [63:0]          shim_outd,
  input  logic                 shimq_empty,
  input  logic                 release_en,
  input  logic                 err_clr,
  output logic                 shimq_read,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  output logic                 cnt_ovf,
  output logic                 rd_underrun
);

  localparam logic [GAP_W-1:0]     GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;
  localparam logic [PKT_CNT_W-1:0] CNT_MAX  = '1;

  state_e               state_q, state_d;
  logic                 shimq_read_q, shimq_read_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 cnt_ovf_q, cnt_ovf_d;
  logic                 rd_underrun_q, rd_underrun_d;

  logic in_is_term, out_is_term;
  logic term_in, term_out;
  logic ovf_set, underrun_set;

  shim_term_detect u_term_wr (
    .sync    (shim_inc),
    .d       (shim_ind),
    .is_term (in_is_term)
  );

  shim_term_detect u_term_rd (
    .sync    (shim_outc),
    .d       (shim_outd),
    .is_term (out_is_term)
  );

  assign term_in  = shimq_write & in_is_term;
  assign term_out = shimq_read_q & ~shimq_empty & out_is_term;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    ovf_set   = 1'b0;
    if (term_in && !term_out) begin
      if (pkt_cnt_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end else if (term_out && !term_in && (pkt_cnt_q != '0)) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
  end

  // A fresh error event on the same edge as err_clr keeps the flag set.
  assign underrun_set = (state_q == RELEASE) & shimq_read_q & shimq_empty;

  always_comb begin
    cnt_ovf_d     = ovf_set      ? 1'b1 : (err_clr ? 1'b0 : cnt_ovf_q);
    rd_underrun_d = underrun_set ? 1'b1 : (err_clr ? 1'b0 : rd_underrun_q);
  end

  always_comb begin
    state_d      = state_q;
    shimq_read_d = 1'b0;
    gap_d        = gap_q;
    case (state_q)
      IDLE: begin
        if (release_en && (pkt_cnt_q != '0)) begin
          state_d      = RELEASE;
          shimq_read_d = 1'b1;
        end
      end
      RELEASE: begin
        shimq_read_d = 1'b1;
        if (term_out) begin
          shimq_read_d = 1'b0;
          if (MIN_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shimq_read_q  <= 1'b0;
      pkt_cnt_q     <= '0;
      gap_q         <= '0;
      cnt_ovf_q     <= 1'b0;
      rd_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shimq_read_q  <= shimq_read_d;
      pkt_cnt_q     <= pkt_cnt_d;
      gap_q         <= gap_d;
      cnt_ovf_q     <= cnt_ovf_d;
      rd_underrun_q <= rd_underrun_d;
    end
  end

  assign shimq_read  = shimq_read_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign cnt_ovf     = cnt_ovf_q;
  assign rd_underrun = rd_underrun_q;

endmodule
